// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, issues single outstanding reads to
// instruction memory and hands returned words to the decoder.
module instr_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            misalign_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            drop;

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            drop         <= 1'b0;
            instr_valid  <= 1'b0;
            instr        <= '0;
            instr_pc     <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            if (redirect) begin
                // Redirect wins over every other event; a word returning in
                // the same cycle is stale and is discarded without arming drop.
                pc           <= {redirect_pc[XLEN-1:2], 2'b00};
                misalign_err <= |redirect_pc[1:0];
                case (state)
                    IDLE: state <= REQ;
                    REQ: begin
                        if (imem_gnt) begin
                            state <= WAIT;
                            drop  <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (imem_rvalid) begin
                            drop  <= 1'b0;
                            state <= REQ;
                        end else begin
                            drop <= 1'b1;
                        end
                    end
                    HOLD: begin
                        instr_valid <= 1'b0;
                        state       <= REQ;
                    end
                    default: state <= IDLE;
                endcase
            end else begin
                case (state)
                    IDLE: state <= REQ;
                    REQ: begin
                        if (imem_gnt) state <= WAIT;
                    end
                    WAIT: begin
                        if (imem_rvalid) begin
                            if (drop) begin
                                drop  <= 1'b0;
                                state <= REQ;
                            end else begin
                                instr       <= imem_rdata;
                                instr_pc    <= pc;
                                instr_valid <= 1'b1;
                                pc          <= pc + XLEN'(4);
                                state       <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (instr_ready) begin
                            instr_valid <= 1'b0;
                            state       <= REQ;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed scoreboard bench for instr_fetch_unit with a 1-cycle memory model
// driven from the stimulus sequence.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misalign_err;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [63:0] sb[$];

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) return;
            tick();
        end
        check("req_timeout", 32'(imem_req), 32'd1);
    endtask

    // Grant immediately, return data one cycle later; push the expected
    // decoder output when the word is supposed to reach the decoder.
    task automatic issue(input logic [31:0] exp_addr, input logic [31:0] data, input bit keep);
        wait_req();
        check("req_addr", imem_addr, exp_addr);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check("req_low_wait", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        if (keep) sb.push_back({exp_addr, data});
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic consume();
        logic [63:0] e;
        check("valid_hold", 32'(instr_valid), 32'd1);
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("instr", instr, e[31:0]);
            check("instr_pc", instr_pc, e[63:32]);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("valid_drop", 32'(instr_valid), 32'd0);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        tick();
        redirect    = 1'b0;
    endtask

    initial begin
        logic [31:0] held_i, held_pc;
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        repeat (3) tick();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Sequential fetch, 3-cycle cadence
        issue(32'h0, 32'h00500093, 1'b1); consume();
        check("cadence_req", 32'(imem_req), 32'd1);
        issue(32'h4, 32'h00a00113, 1'b1); consume();
        issue(32'h8, 32'h002081b3, 1'b1); consume();

        // Decoder stall in HOLD
        issue(32'hC, 32'hdeadbeef, 1'b1);
        held_i = instr; held_pc = instr_pc;
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_instr", instr, held_i);
            check("stall_pc", instr_pc, held_pc);
            check("stall_req", 32'(imem_req), 32'd0);
        end
        consume();

        // Redirect while in WAIT: late word dropped
        wait_req();
        check("pre_wait_addr", imem_addr, 32'h10);
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        do_redirect(32'h100);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h11111111; tick(); imem_rvalid = 1'b0;
        check("drop_valid", 32'(instr_valid), 32'd0);
        check("drop_req", 32'(imem_req), 32'd1);
        check("drop_addr", imem_addr, 32'h100);
        issue(32'h100, 32'h12345678, 1'b1); consume();

        // Redirect in HOLD with ready=1 squashes
        issue(32'h104, 32'h22222222, 1'b0);
        check("squash_pre", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        do_redirect(32'h200);
        instr_ready = 1'b0;
        check("squash_valid", 32'(instr_valid), 32'd0);
        check("squash_addr", imem_addr, 32'h200);

        // Misaligned redirect
        do_redirect(32'h103);
        check("mis_pulse", 32'(misalign_err), 32'd1);
        check("mis_addr", imem_addr, 32'h100);
        tick();
        check("mis_clear", 32'(misalign_err), 32'd0);
        issue(32'h100, 32'h33333333, 1'b1); consume();

        // Redirect coincident with grant
        wait_req();
        imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        imem_gnt = 1'b0; redirect = 1'b0;
        check("cg_misalign", 32'(misalign_err), 32'd0);
        check("cg_wait", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h44444444; tick(); imem_rvalid = 1'b0;
        check("cg_valid", 32'(instr_valid), 32'd0);
        check("cg_addr", imem_addr, 32'h300);

        // PC wrap
        do_redirect(32'hFFFFFFFC);
        issue(32'hFFFFFFFC, 32'h55555555, 1'b1); consume();
        check("wrap_addr", imem_addr, 32'h0);

        // Async reset while in WAIT
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_req", 32'(imem_req), 32'd0);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_instr", instr, 32'h0);
        check("arst_pc", instr_pc, 32'h0);
        tick();
        rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h66666666;
        tick();
        check("late_rv_valid", 32'(instr_valid), 32'd0);
        check("late_rv_req", 32'(imem_req), 32'd1);
        tick();
        imem_rvalid = 1'b0;
        check("rv_req_valid", 32'(instr_valid), 32'd0);
        issue(32'h0, 32'h77777777, 1'b1); consume();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
